// File: rtl/cfg_pkg.sv
// Shared definitions for the CLB configuration-chain loader.
package cfg_pkg;

  localparam int unsigned CLB_CFG_BITS = 27;

  // Field offsets inside one CLB's configuration word.
  localparam int unsigned CLB_IN_OFS  = 0;
  localparam int unsigned CLB_LUT_OFS = 6;
  localparam int unsigned CLB_FF_OFS  = 22;
  localparam int unsigned CLB_OUT_OFS = 25;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StSettle,
    StDone
  } cfg_state_t;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register; emits LSB first and tracks the current lane.
module cfg_piso #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              sout_o,
  output logic              last_o
);

  localparam int unsigned LaneW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [LaneW-1:0]  lane_q, lane_d;

  always_comb begin
    sreg_d = sreg_q;
    lane_d = lane_q;
    if (load_i) begin
      sreg_d = data_i;
      lane_d = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q >> 1;
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      lane_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      lane_q <= lane_d;
    end
  end

  assign sout_o = sreg_q[0];
  assign last_o = (lane_q == LaneW'(WORD_W - 1));

endmodule

// File: rtl/cfg_loader.sv
// Loads a column of daisy-chained CLBs: serialises bitstream words onto the config chain,
// shifting exactly NUM_CLBS*CLB_CFG_BITS bits while holding the fabric in reset.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned NUM_CLBS      = 4,
  parameter int unsigned WORD_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned TOTAL_BITS   = NUM_CLBS * CLB_CFG_BITS,
  localparam int unsigned CNT_W        = $clog2(TOTAL_BITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              cfg_en,
  output logic              cfg_out,
  output logic              fabric_reset,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  cfg_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic aborted_q, aborted_d;
  logic fabric_reset_q, fabric_reset_d;
  logic s_ready_q, s_ready_d;
  logic cfg_en_q, cfg_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic piso_load, piso_shift, piso_last, in_busy;

  assign in_busy = state_q inside {StLoad, StShift, StSettle};

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    settle_d    = settle_q;
    aborted_d   = aborted_q;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;

    // Abort beats everything while busy; bit_count is kept for debug.
    if (in_busy && abort) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StLoad;
            bit_count_d = '0;
            aborted_d   = 1'b0;
          end
        end
        StLoad: begin
          if (s_valid) begin
            piso_load = 1'b1;
            state_d   = StShift;
          end
        end
        StShift: begin
          piso_shift  = 1'b1;
          bit_count_d = bit_count_q + 1'b1;
          if (bit_count_q == CNT_W'(TOTAL_BITS - 1)) begin
            state_d  = StSettle;
            settle_d = '0;
          end else if (piso_last) begin
            state_d = StLoad;
          end
        end
        StSettle: begin
          if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
            state_d = StDone;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_d     = StLoad;
            bit_count_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    s_ready_d = (state_d == StLoad);
    cfg_en_d  = (state_d == StShift);
    busy_d    = state_d inside {StLoad, StShift, StSettle};
    done_d    = (state_d == StDone);
    if (state_d == StDone) begin
      fabric_reset_d = 1'b0;
    end else if (state_d == StIdle) begin
      fabric_reset_d = fabric_reset_q;
    end else begin
      fabric_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      bit_count_q    <= '0;
      settle_q       <= '0;
      aborted_q      <= 1'b0;
      fabric_reset_q <= 1'b1;
      s_ready_q      <= 1'b0;
      cfg_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_count_q    <= bit_count_d;
      settle_q       <= settle_d;
      aborted_q      <= aborted_d;
      fabric_reset_q <= fabric_reset_d;
      s_ready_q      <= s_ready_d;
      cfg_en_q       <= cfg_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  cfg_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .clk    (clk),
    .reset  (reset),
    .load_i (piso_load),
    .shift_i(piso_shift),
    .data_i (s_data),
    .sout_o (cfg_out),
    .last_o (piso_last)
  );

  assign s_ready      = s_ready_q;
  assign cfg_en       = cfg_en_q;
  assign fabric_reset = fabric_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: a 4-CLB and a 1-CLB instance driven with random bitstreams,
// checked against an index-arithmetic model of where each stream bit lands in the chain.
module tb_cfg_loader;
  import cfg_pkg::*;

  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int T0     = 4 * CLB_CFG_BITS;
  localparam int T1     = CLB_CFG_BITS;
  localparam int BC0    = $clog2(T0 + 1);
  localparam int BC1    = $clog2(T1 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, abort, s_valid;
  logic [W-1:0] s_data;
  logic s_ready0, cfg_en0, cfg_out0, fr0, busy0, done0, ab0;
  logic s_ready1, cfg_en1, cfg_out1, fr1, busy1, done1, ab1;
  logic [BC0-1:0] bc0;
  logic [BC1-1:0] bc1;

  cfg_loader #(.NUM_CLBS(4), .WORD_W(W), .SETTLE_CYCLES(SETTLE)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready0), .s_data(s_data), .cfg_en(cfg_en0), .cfg_out(cfg_out0),
    .fabric_reset(fr0), .busy(busy0), .done(done0), .aborted(ab0), .bit_count(bc0)
  );

  cfg_loader #(.NUM_CLBS(1), .WORD_W(W), .SETTLE_CYCLES(SETTLE)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready1), .s_data(s_data), .cfg_en(cfg_en1), .cfg_out(cfg_out1),
    .fabric_reset(fr1), .busy(busy1), .done(done1), .aborted(ab1), .bit_count(bc1)
  );

  // sel picks which instance the monitor and driver look at.
  logic sel;
  logic m_start, m_s_ready, m_cfg_en, m_cfg_out, m_fr, m_busy, m_done;
  logic [BC0-1:0] m_bc;
  assign m_start   = sel ? start1 : start0;
  assign m_s_ready = sel ? s_ready1 : s_ready0;
  assign m_cfg_en  = sel ? cfg_en1 : cfg_en0;
  assign m_cfg_out = sel ? cfg_out1 : cfg_out0;
  assign m_fr      = sel ? fr1 : fr0;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_done    = sel ? done1 : done0;
  assign m_bc      = sel ? BC0'(bc1) : bc0;

  int checks = 0;
  int errors = 0;

  int   cyc = 0, en_cnt = 0, last_en_cyc = 0, start_cyc = 0, done_rise_cyc = 0;
  logic prev_done = 1'b0, prev_fr = 1'b1, fr_at_rise = 1'b1, fr_before_rise = 1'b0;
  logic bits_q[$];

  always @(negedge clk) begin
    cyc++;
    if (m_cfg_en === 1'b1) begin
      bits_q.push_back(m_cfg_out);
      en_cnt++;
      last_en_cyc = cyc;
    end
    if (m_start === 1'b1 && m_busy !== 1'b1) start_cyc = cyc;
    if (m_done === 1'b1 && prev_done !== 1'b1) begin
      done_rise_cyc  = cyc;
      fr_at_rise     = m_fr;
      fr_before_rise = prev_fr;
    end
    prev_done = m_done;
    prev_fr   = m_fr;
  end

  logic [W-1:0] words [16];
  int en_base, bit_base;

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) words[i] = W'($urandom);
  endtask

  // Status: 0 = reached done, 1 = stopped at bit_count==stop_bits (at a negedge), 2 = timeout.
  task automatic drive_load(input int total, input bit toggle, input bit do_start,
                            input int spur_n, input int stop_bits, output int status);
    int idx;
    int nwords;
    idx    = 0;
    nwords = (total + W - 1) / W;
    status = 2;
    en_base  = en_cnt;
    bit_base = bits_q.size();
    if (do_start) begin
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
    end
    for (int n = 0; n < 3000; n++) begin
      s_valid = (idx < nwords) && (!toggle || (n % 2 == 0));
      s_data  = words[idx % 16];
      set_start(n == spur_n);
      @(negedge clk);
      if (m_done === 1'b1) begin
        status = 0;
        break;
      end
      if (stop_bits >= 0 && int'(m_bc) == stop_bits) begin
        status = 1;
        break;
      end
      if (s_valid && m_s_ready === 1'b1) idx++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    set_start(1'b0);
    if (status == 0) begin
      @(posedge clk); #1;
    end
  endtask

  // Expected chain contents: stream bit j ends at chain position total-1-j (0 = head).
  function automatic logic [CLB_CFG_BITS-1:0] exp_clb(input int total, input int c);
    logic [CLB_CFG_BITS-1:0] r;
    logic [W-1:0] w;
    int j;
    for (int k = 0; k < CLB_CFG_BITS; k++) begin
      j    = total - 1 - (c * CLB_CFG_BITS + k);
      w    = words[j / W];
      r[k] = w[j % W];
    end
    return r;
  endfunction

  // Chain as seen by the CLBs: replay recorded cfg_out bits through a shift register.
  function automatic logic [CLB_CFG_BITS-1:0] got_clb(input int base, input int total,
                                                      input int c);
    logic [T0-1:0] chain;
    logic b;
    chain = '0;
    for (int j = 0; j < total; j++) begin
      b     = (base + j < bits_q.size()) ? bits_q[base + j] : 1'b0;
      chain = {chain[T0-2:0], b};
    end
    return chain[c * CLB_CFG_BITS +: CLB_CFG_BITS];
  endfunction

  task automatic test_reset();
    sel = 1'b0; reset = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready0, cfg_en0, cfg_out0, fr0, busy0, done0, ab0} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_outs0: got %b expected 0001000",
               {s_ready0, cfg_en0, cfg_out0, fr0, busy0, done0, ab0});
    end
    checks++;
    if ({s_ready1, cfg_en1, cfg_out1, fr1, busy1, done1, ab1} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_outs1: got %b expected 0001000",
               {s_ready1, cfg_en1, cfg_out1, fr1, busy1, done1, ab1});
    end
    checks++;
    if (bc0 !== '0 || bc1 !== '0) begin
      errors++;
      $display("FAIL reset_bitcount: got %0d/%0d expected 0/0", bc0, bc1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    int st;
    logic [T1-1:0] g, e;
    logic [W-1:0] w;
    sel = 1'b1;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h05;
    drive_load(T1, 1'b0, 1'b1, -1, -1, st);
    checks++;
    if (st != 0) begin errors++; $display("FAIL small_done: status %0d expected 0", st); end
    checks++;
    if (en_cnt - en_base != T1) begin
      errors++; $display("FAIL small_en_count: got %0d expected %0d", en_cnt - en_base, T1);
    end
    for (int j = 0; j < T1; j++) begin
      g[j] = (bit_base + j < bits_q.size()) ? bits_q[bit_base + j] : 1'bx;
      w    = words[j / W];
      e[j] = w[j % W];
    end
    checks++;
    if (g !== e) begin errors++; $display("FAIL small_stream: got %h expected %h", g, e); end
    checks++;
    if (g[7:0] !== 8'b10100101) begin
      errors++; $display("FAIL small_first8: got %b expected 10100101", g[7:0]);
    end
    checks++;
    if ({g[26], g[25], g[24]} !== 3'b101) begin
      errors++; $display("FAIL small_last3: got %b expected 101", {g[26], g[25], g[24]});
    end
    checks++;
    if (done_rise_cyc - last_en_cyc != SETTLE + 1) begin
      errors++;
      $display("FAIL small_settle: got %0d expected %0d", done_rise_cyc - last_en_cyc, SETTLE + 1);
    end
    checks++;
    if (done_rise_cyc - start_cyc != 4 + T1 + SETTLE + 1) begin
      errors++;
      $display("FAIL small_load_time: got %0d expected %0d", done_rise_cyc - start_cyc,
               4 + T1 + SETTLE + 1);
    end
    checks++;
    if ({fr_before_rise, fr_at_rise} !== 2'b10) begin
      errors++;
      $display("FAIL small_fr_fall: got %b expected 10", {fr_before_rise, fr_at_rise});
    end
    checks++;
    if (got_clb(bit_base, T1, 0) !== exp_clb(T1, 0)) begin
      errors++;
      $display("FAIL small_chain: got %h expected %h", got_clb(bit_base, T1, 0), exp_clb(T1, 0));
    end
    checks++;
    if (int'(bc1) != T1) begin errors++; $display("FAIL small_bitcount: got %0d expected %0d", bc1, T1); end
    sel = 1'b0;
  endtask

  task automatic test_toggle();
    int st;
    rand_words();
    drive_load(T0, 1'b1, 1'b1, -1, -1, st);
    checks++;
    if (st != 0) begin errors++; $display("FAIL toggle_done: status %0d expected 0", st); end
    checks++;
    if (en_cnt - en_base != T0) begin
      errors++; $display("FAIL toggle_en_count: got %0d expected %0d", en_cnt - en_base, T0);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (got_clb(bit_base, T0, c) !== exp_clb(T0, c)) begin
        errors++;
        $display("FAIL toggle_clb%0d: got %h expected %h", c, got_clb(bit_base, T0, c),
                 exp_clb(T0, c));
      end
    end
    checks++;
    if ({int'(bc0), done0, busy0, fr0} !== {T0, 3'b100}) begin
      errors++;
      $display("FAIL toggle_final: got bc=%0d done=%b busy=%b fr=%b expected 108 1 0 0",
               bc0, done0, busy0, fr0);
    end
  endtask

  task automatic test_abort();
    int st;
    rand_words();
    drive_load(T0, 1'b0, 1'b1, -1, 40, st);
    checks++;
    if (st != 1) begin errors++; $display("FAIL abort_reach40: status %0d expected 1", st); end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({cfg_en0, busy0, ab0, fr0, done0} !== 5'b00110) begin
      errors++;
      $display("FAIL abort_outs: got %b expected 00110", {cfg_en0, busy0, ab0, fr0, done0});
    end
    checks++;
    if (int'(bc0) != 40) begin errors++; $display("FAIL abort_bitcount: got %0d expected 40", bc0); end
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ab0, int'(bc0), s_ready0} !== {1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL abort_restart: got aborted=%b bc=%0d s_ready=%b expected 0 0 1",
               ab0, bc0, s_ready0);
    end
    @(posedge clk); #1;
    rand_words();
    drive_load(T0, 1'b0, 1'b0, -1, -1, st);
    checks++;
    if (st != 0 || en_cnt - en_base != T0) begin
      errors++;
      $display("FAIL abort_reload: status %0d en %0d expected 0 %0d", st, en_cnt - en_base, T0);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (got_clb(bit_base, T0, c) !== exp_clb(T0, c)) begin
        errors++;
        $display("FAIL abort_clb%0d: got %h expected %h", c, got_clb(bit_base, T0, c),
                 exp_clb(T0, c));
      end
    end
  endtask

  task automatic test_start_shift_done();
    int st;
    rand_words();
    drive_load(T0, 1'b0, 1'b1, 20, -1, st);
    checks++;
    if (st != 0 || en_cnt - en_base != T0) begin
      errors++;
      $display("FAIL spur_start_en: status %0d en %0d expected 0 %0d", st, en_cnt - en_base, T0);
    end
    checks++;
    if (done_rise_cyc - start_cyc != 14 + T0 + SETTLE + 1) begin
      errors++;
      $display("FAIL spur_start_time: got %0d expected %0d", done_rise_cyc - start_cyc,
               14 + T0 + SETTLE + 1);
    end
    checks++;
    if (got_clb(bit_base, T0, 3) !== exp_clb(T0, 3)) begin
      errors++;
      $display("FAIL spur_start_clb3: got %h expected %h", got_clb(bit_base, T0, 3),
               exp_clb(T0, 3));
    end
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({fr0, done0, busy0, s_ready0, int'(bc0)} !== {4'b1011, 32'd0}) begin
      errors++;
      $display("FAIL done_restart: got fr=%b done=%b busy=%b s_ready=%b bc=%0d expected 1 0 1 1 0",
               fr0, done0, busy0, s_ready0, bc0);
    end
    @(posedge clk); #1;
    rand_words();
    drive_load(T0, 1'b0, 1'b0, -1, -1, st);
    checks++;
    if (st != 0 || en_cnt - en_base != T0) begin
      errors++;
      $display("FAIL done_reload: status %0d en %0d expected 0 %0d", st, en_cnt - en_base, T0);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (got_clb(bit_base, T0, c) !== exp_clb(T0, c)) begin
        errors++;
        $display("FAIL done_clb%0d: got %h expected %h", c, got_clb(bit_base, T0, c),
                 exp_clb(T0, c));
      end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    rand_words();
    drive_load(T0, 1'b0, 1'b1, -1, 12, st);
    checks++;
    if (st != 1 || cfg_en0 !== 1'b1) begin
      errors++; $display("FAIL rstmid_reach: status %0d cfg_en %b expected 1 1", st, cfg_en0);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready0, cfg_en0, cfg_out0, fr0, busy0, done0, ab0, int'(bc0)} !==
        {7'b0001000, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_outs: got %b bc=%0d expected 0001000 bc=0",
               {s_ready0, cfg_en0, cfg_out0, fr0, busy0, done0, ab0}, bc0);
    end
    @(posedge clk); #1 s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready0 !== 1'b0) begin
        errors++; $display("FAIL rstmid_ready%0d: got %b expected 0", i, s_ready0);
      end
    end
    @(posedge clk); #1 s_valid = 1'b0;
  endtask

  task automatic test_start_abort();
    int st;
    start0 = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start0 = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready0, busy0, ab0} !== 3'b110) begin
      errors++;
      $display("FAIL idle_start_abort: got %b expected 110", {s_ready0, busy0, ab0});
    end
    @(posedge clk); #1;
    rand_words();
    drive_load(T0, 1'b0, 1'b0, -1, 3, st);
    checks++;
    if (st != 1 || cfg_en0 !== 1'b1) begin
      errors++; $display("FAIL shift_reach: status %0d cfg_en %b expected 1 1", st, cfg_en0);
    end
    start0 = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start0 = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, ab0, cfg_en0, s_ready0, done0, fr0} !== 6'b010001) begin
      errors++;
      $display("FAIL shift_start_abort: got %b expected 010001",
               {busy0, ab0, cfg_en0, s_ready0, done0, fr0});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_small();
    test_toggle();
    test_abort();
    test_start_shift_done();
    test_reset_mid();
    test_start_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
